unary_add_host: RTL and testbench

Host-side driver and collector for the base-9 unary adder digit slice (`Unary_add_1_4_8` port set).
- **Request side:** accepts two binary digits per operation and serializes them into the adder's unary A/B input streams during a read phase.
- **Result side:** switches the adder to its write phase, counts the unary `dout` pulses back into a binary sum digit, and captures the carry pulse.
- **Placement:** between the binary operand/result interface and one adder slice.

---
 rtl/unary_pkg.sv | 20 ++
 rtl/unary_add_host_if.sv | 30 +++
 rtl/unary_serializer.sv | 21 ++
 rtl/unary_add_host.sv | 134 +++++++++++++
 tb/tb_unary_add_host.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/unary_pkg.sv
// Shared constants, state encoding and digit helper for the base-9 unary adder host.
package unary_pkg;

  localparam int RADIX     = 9;
  localparam int DIGIT_MAX = RADIX - 1;
  localparam int DIGIT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } host_state_t;

  // Clamp an incoming binary digit to the largest legal base-9 value.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(DIGIT_MAX)) ? DIGIT_W'(DIGIT_MAX) : d;
  endfunction

endpackage

// File: rtl/unary_add_host_if.sv
// Operand/result bus plus adder-side unary streams of the unary adder host.
interface unary_add_host_if;

  logic                          start;
  logic [unary_pkg::DIGIT_W-1:0] a_dig;
  logic [unary_pkg::DIGIT_W-1:0] b_dig;
  logic                          busy;
  logic                          done;
  logic [unary_pkg::DIGIT_W-1:0] sum_dig;
  logic                          carry;
  logic                          err;
  logic                          en;
  logic                          read_or_write;
  logic                          A;
  logic                          B;
  logic                          dout;
  logic                          C;

  // slave: the host block itself; master: whoever supplies operands and models the adder.
  modport slave (
    input  start, a_dig, b_dig, dout, C,
    output busy, done, sum_dig, carry, err, en, read_or_write, A, B
  );

  modport master (
    output start, a_dig, b_dig, dout, C,
    input  busy, done, sum_dig, carry, err, en, read_or_write, A, B
  );

endinterface

// File: rtl/unary_serializer.sv
// Thermometer encoder: emits a one while the phase counter is below the digit.
module unary_serializer
  import unary_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0]   i_k,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic               o_bit
);

  localparam int W = (CNT_W > DIGIT_W) ? CNT_W : DIGIT_W;

  logic [W-1:0] w_k;
  logic [W-1:0] w_d;

  assign w_k   = W'(i_k);
  assign w_d   = W'(i_digit);
  assign o_bit = (w_k < w_d);

endmodule

// File: rtl/unary_add_host.sv
// Host for one base-9 unary adder slice: serializes two digits, then counts the unary result back.
module unary_add_host
  import unary_pkg::*;
#(
  parameter int READ_LEN  = 8,
  parameter int WRITE_LEN = 10
) (
  input logic             clk,
  input logic             rst,
  unary_add_host_if.slave bus
);

  localparam int CNT_MAX = (READ_LEN > WRITE_LEN) ? READ_LEN : WRITE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  host_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DIGIT_W-1:0] r_a_q, r_b_q, w_a_nxt, w_b_nxt;
  logic [DIGIT_W-1:0] r_sum;
  logic               r_carry, r_err;
  logic               r_en, r_rw, r_a, r_b;
  logic               w_accept, w_a_bit, w_b_bit, w_carry_win;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_a_nxt  = w_accept ? sat_digit(bus.a_dig) : r_a_q;
  assign w_b_nxt  = w_accept ? sat_digit(bus.b_dig) : r_b_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = READ;
          w_cnt_nxt   = '0;
        end
      end
      READ: begin
        if (r_cnt == CNT_W'(READ_LEN - 1)) begin
          w_state_nxt = WRITE;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      WRITE: begin
        if (r_cnt == CNT_W'(WRITE_LEN)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Serializers look at next-state values so A/B are registered and stable for the whole cycle.
  unary_serializer #(.CNT_W(CNT_W)) u_ser_a (
    .i_k     (w_cnt_nxt),
    .i_digit (w_a_nxt),
    .o_bit   (w_a_bit)
  );

  unary_serializer #(.CNT_W(CNT_W)) u_ser_b (
    .i_k     (w_cnt_nxt),
    .i_digit (w_b_nxt),
    .o_bit   (w_b_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a_q   <= '0;
      r_b_q   <= '0;
      r_en    <= 1'b0;
      r_rw    <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a_q   <= w_a_nxt;
      r_b_q   <= w_b_nxt;
      r_en    <= (w_state_nxt == READ) || (w_state_nxt == WRITE);
      r_rw    <= (w_state_nxt == WRITE);
      r_a     <= (w_state_nxt == READ) && w_a_bit;
      r_b     <= (w_state_nxt == READ) && w_b_bit;
    end
  end

  // Adder carry can appear from READ cycle 2 and, from the last READ edge, in WRITE cycle 1.
  assign w_carry_win = ((r_state == READ) && (r_cnt != '0)) ||
                       ((r_state == WRITE) && (r_cnt == CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_carry_win && bus.C) r_carry <= 1'b1;
      if ((r_state == WRITE) && bus.dout) begin
        if (r_sum != {DIGIT_W{1'b1}}) r_sum <= r_sum + 4'd1;
        if (r_cnt == CNT_W'(WRITE_LEN)) r_err <= 1'b1;
      end
    end
  end

  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = (r_state == DONE);
  assign bus.sum_dig       = r_sum;
  assign bus.carry         = r_carry;
  assign bus.err           = r_err;
  assign bus.en            = r_en;
  assign bus.read_or_write = r_rw;
  assign bus.A             = r_a;
  assign bus.B             = r_b;

endmodule

// File: tb/tb_unary_add_host.sv
// Bench for unary_add_host: behavioural base-9 adder model plus a result scoreboard.
module tb_unary_add_host;

  typedef struct {
    logic [3:0] sum;
    logic       carry;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   force_dout = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  unary_add_host_if bus ();

  unary_add_host dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural adder slice: accumulates unary inputs, pulses C on wrap, replays remainder.
  int   m_acc;
  int   m_wj;
  logic m_c;
  logic m_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= 0; m_wj <= 0; m_c <= 1'b0; m_dout <= 1'b0;
    end else if (!bus.en) begin
      m_acc <= 0; m_wj <= 0; m_c <= 1'b0; m_dout <= 1'b0;
    end else if (!bus.read_or_write) begin
      if (m_acc + int'(bus.A) + int'(bus.B) >= 9) begin
        m_acc <= m_acc + int'(bus.A) + int'(bus.B) - 9;
        m_c   <= 1'b1;
      end else begin
        m_acc <= m_acc + int'(bus.A) + int'(bus.B);
        m_c   <= 1'b0;
      end
      m_dout <= 1'b0;
    end else begin
      m_wj   <= m_wj + 1;
      m_dout <= ((m_wj + 1) <= m_acc);
      m_c    <= 1'b0;
    end
  end

  assign bus.dout = force_dout ? (bus.en & bus.read_or_write) : m_dout;
  assign bus.C    = m_c;

  // Stream monitor: counts ones presented during READ and carry pulses seen.
  int a_ones = 0;
  int b_ones = 0;
  int c_pulses = 0;

  always @(negedge clk) begin
    if (bus.en && !bus.read_or_write) begin
      a_ones <= a_ones + int'(bus.A);
      b_ones <= b_ones + int'(bus.B);
    end
    if (bus.C) c_pulses <= c_pulses + 1;
  end

  task automatic run_op(input int a, input int b, input bit frc, input int read_pulse,
                        input bit done_pulse, input string name, output int c_seen);
    exp_t e, got;
    int sa, sb, s, cyc, a0, b0, c0;
    sa = (a > 8) ? 8 : a;
    sb = (b > 8) ? 8 : b;
    s  = sa + sb;
    e.carry = (s >= 9);
    e.sum   = 4'(e.carry ? s - 9 : s);
    e.err   = 1'b0;
    if (frc) begin
      e.sum = 4'd10;
      e.err = 1'b1;
    end
    force_dout = frc;

    @(negedge clk);
    bus.start = 1'b1;
    bus.a_dig = 4'(a);
    bus.b_dig = 4'(b);
    exp_q.push_back(e);
    a0 = a_ones; b0 = b_ones; c0 = c_pulses;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    n_checks++;
    if ({bus.busy, bus.sum_dig, bus.carry, bus.err} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s accept_clear: busy/sum/carry/err=%b/%0d/%b/%b required 1/0/0/0",
               name, bus.busy, bus.sum_dig, bus.carry, bus.err);
    end

    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == read_pulse) begin
        bus.start = 1'b1;
        bus.a_dig = 4'd8;
        bus.b_dig = 4'd8;
      end else if (cyc == read_pulse + 1) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;

    n_checks++;
    if (cyc !== 19) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d required 19%s", name, cyc,
               (bus.done !== 1'b1) ? " (timeout)" : "");
    end
    c_seen = c_pulses - c0;

    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty: got 0 entries required 1", name);
    end else begin
      got = exp_q.pop_front();
      if (bus.sum_dig !== got.sum || bus.carry !== got.carry || bus.err !== got.err) begin
        n_fail++;
        $display("FAIL %s result: sum/carry/err=%0d/%b/%b required %0d/%b/%b",
                 name, bus.sum_dig, bus.carry, bus.err, got.sum, got.carry, got.err);
      end
    end

    n_checks++;
    if ((a_ones - a0) !== sa || (b_ones - b0) !== sb) begin
      n_fail++;
      $display("FAIL %s unary_len: A/B ones=%0d/%0d required %0d/%0d",
               name, a_ones - a0, b_ones - b0, sa, sb);
    end

    if (done_pulse) begin
      bus.start = 1'b1;
      bus.a_dig = 4'd1;
      bus.b_dig = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s start_in_done: busy/done=%b/%b required 0/0", name, bus.busy, bus.done);
      end
    end
    force_dout = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.a_dig = 4'd0;
    bus.b_dig = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.sum_dig, bus.carry, bus.err,
         bus.en, bus.read_or_write, bus.A, bus.B} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%0d carry=%b err=%b en=%b rw=%b A=%b B=%b required all 0",
               bus.busy, bus.done, bus.sum_dig, bus.carry, bus.err,
               bus.en, bus.read_or_write, bus.A, bus.B);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.en} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/en=%b/%b required 0/0", bus.busy, bus.en);
    end
  endtask

  task automatic test_basic;
    int c;
    run_op(3, 4, 1'b0, 0, 1'b0, "add_3_4", c);
  endtask

  task automatic test_carry;
    int c;
    run_op(4, 5, 1'b0, 0, 1'b0, "add_4_5", c);
    run_op(8, 8, 1'b0, 0, 1'b0, "add_8_8", c);
    n_checks++;
    if (c !== 1) begin
      n_fail++;
      $display("FAIL add_8_8 carry_pulses: got %0d required 1", c);
    end
  endtask

  task automatic test_zero_and_saturation;
    int c;
    run_op(0, 0, 1'b0, 0, 1'b0, "add_0_0", c);
    run_op(12, 0, 1'b0, 0, 1'b0, "add_12_0", c);
  endtask

  task automatic test_back_to_back;
    int c;
    run_op(2, 3, 1'b0, 4, 1'b1, "start_in_read_done", c);
    run_op(6, 7, 1'b0, 0, 1'b0, "b2b_first", c);
    run_op(1, 5, 1'b0, 0, 1'b0, "b2b_second", c);
  endtask

  task automatic test_reset_mid;
    int c;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_dig = 4'd6;
    bus.b_dig = 4'd6;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.en, bus.A, bus.B, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_read: en/A/B/busy=%b/%b/%b/%b required 0/0/0/0",
               bus.en, bus.A, bus.B, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(2, 2, 1'b0, 0, 1'b0, "after_reset_2_2", c);
  endtask

  task automatic test_dout_stuck;
    int c;
    run_op(1, 1, 1'b1, 0, 1'b0, "dout_stuck", c);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero_and_saturation();
    test_back_to_back();
    test_reset_mid();
    test_dout_stuck();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
